// File: rtl/psec5_spi_master_if.sv
// psec5_spi_master_if
//   Local command/response bus between controller logic and psec5_spi_master.
//
//   Handshake: a command byte transfers on a rising clk edge where cmd_valid
//   and cmd_ready are both high and irst_req is low. The issuer holds
//   cmd_data/cmd_last stable while cmd_valid is high. rsp_valid is a
//   single-cycle pulse with no back-pressure, so the issuer must take
//   rsp_data in that cycle.
//
//   Signals:
//     cmd_valid / cmd_ready  command handshake
//     cmd_data [7:0]         byte to shift out (address first, then data)
//     cmd_last               issue an iclk reset burst after this byte
//     irst_req               standalone reset-burst request, sampled in IDLE
//     rsp_valid / rsp_data   captured read byte, one-cycle pulse
//     busy                   master is not idle
//
//   Modports: master = command issuer, slave = psec5_spi_master itself.
interface psec5_spi_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_data;
  logic       cmd_last;
  logic       irst_req;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;

  modport master (
    output cmd_valid, cmd_data, cmd_last, irst_req,
    input  cmd_ready, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  cmd_valid, cmd_data, cmd_last, irst_req,
    output cmd_ready, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/psec5_spi_master.sv
// psec5_spi_master
//   Bit-bangs command bytes MSB-first onto serial_in/sclk for the PSEC5 SPI
//   slave, captures serial_out into a read byte per transfer, and issues the
//   iclk internal-reset burst that ends a transaction.
//
//   Parameters:
//     CLK_DIV      clk cycles per sclk/iclk half-phase (>= 1)
//     IRST_PULSES  iclk pulses per internal-reset burst (>= 1)
//
//   Ports:
//     clk, rstn    system clock, asynchronous active-low reset
//     loopback     (only with PSEC5_SPI_LOOPBACK_EN) sample own serial_in
//     bus          command/response bus, slave modport
//     sclk, iclk   clocks to the chip
//     serial_in    data to the chip
//     serial_out   data from the chip
//     dbg_state    current FSM state encoding
//
//   Optional feature: define PSEC5_SPI_LOOPBACK_EN to add the loopback port.
//
//   Bit timing: LO (CLK_DIV cycles, data set up) -> HI (CLK_DIV cycles, slave
//   samples on the rising edge) -> SMP (1 cycle, master samples serial_out).
module psec5_spi_master #(
  parameter int CLK_DIV     = 2,
  parameter int IRST_PULSES = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
`ifdef PSEC5_SPI_LOOPBACK_EN
  input  logic                 loopback,
`endif
  psec5_spi_master_if.slave    bus,
  output logic                 sclk,
  output logic                 iclk,
  output logic                 serial_in,
  input  logic                 serial_out,
  output logic [2:0]           dbg_state
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int PW = $clog2(IRST_PULSES + 1);
  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PULSE_LAST = PW'(IRST_PULSES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LO   = 3'd1,
    S_HI   = 3'd2,
    S_SMP  = 3'd3,
    S_IRST = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [DW-1:0] div_cnt, div_n;
  logic [2:0]    bit_idx, bit_n;
  logic [PW-1:0] pulse_cnt, pulse_n;
  logic          irst_hi, ihi_n;     // high phase of the current iclk pulse
  logic [7:0]    tx, tx_n;
  logic [7:0]    rx, rx_n;
  logic          last_q, last_n;
  logic          rsp_valid_q, rsp_valid_d;
  logic [7:0]    rsp_data_q, rsp_data_d;
  logic          sclk_d, iclk_d, sin_d;
  logic          phase_done;
  logic          sample_bit;

  assign phase_done = (div_cnt == DIV_LAST);

`ifdef PSEC5_SPI_LOOPBACK_EN
  // serial_in still holds tx[bit] during SMP, so loopback returns cmd_data.
  assign sample_bit = loopback ? serial_in : serial_out;
`else
  assign sample_bit = serial_out;
`endif

  // State register, counters and registered pins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      div_cnt     <= '0;
      bit_idx     <= '0;
      pulse_cnt   <= '0;
      irst_hi     <= 1'b0;
      tx          <= '0;
      rx          <= '0;
      last_q      <= 1'b0;
      sclk        <= 1'b0;
      iclk        <= 1'b0;
      serial_in   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state       <= state_n;
      div_cnt     <= div_n;
      bit_idx     <= bit_n;
      pulse_cnt   <= pulse_n;
      irst_hi     <= ihi_n;
      tx          <= tx_n;
      rx          <= rx_n;
      last_q      <= last_n;
      sclk        <= sclk_d;
      iclk        <= iclk_d;
      serial_in   <= sin_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    div_n   = div_cnt;
    bit_n   = bit_idx;
    pulse_n = pulse_cnt;
    ihi_n   = irst_hi;
    tx_n    = tx;
    rx_n    = rx;
    last_n  = last_q;
    case (state)
      S_IDLE: begin
        // irst_req has priority over a simultaneous command.
        if (bus.irst_req) begin
          state_n = S_IRST;
          div_n   = '0;
          pulse_n = '0;
          ihi_n   = 1'b1;
        end else if (bus.cmd_valid) begin
          state_n = S_LO;
          tx_n    = bus.cmd_data;
          last_n  = bus.cmd_last;
          bit_n   = 3'd7;
          div_n   = '0;
        end
      end
      S_LO: begin
        if (phase_done) begin
          state_n = S_HI;
          div_n   = '0;
        end else begin
          div_n = div_cnt + DW'(1);
        end
      end
      S_HI: begin
        if (phase_done) begin
          state_n = S_SMP;
          div_n   = '0;
        end else begin
          div_n = div_cnt + DW'(1);
        end
      end
      S_SMP: begin
        rx_n[bit_idx] = sample_bit;
        div_n         = '0;
        if (bit_idx != 3'd0) begin
          bit_n   = bit_idx - 3'd1;
          state_n = S_LO;
        end else if (last_q) begin
          state_n = S_IRST;
          pulse_n = '0;
          ihi_n   = 1'b1;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_IRST: begin
        if (phase_done) begin
          div_n = '0;
          if (irst_hi) begin
            ihi_n = 1'b0;
          end else if (pulse_cnt == PULSE_LAST) begin
            state_n = S_IDLE;
          end else begin
            pulse_n = pulse_cnt + PW'(1);
            ihi_n   = 1'b1;
          end
        end else begin
          div_n = div_cnt + DW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Output logic: decode pin values from the next state so the pins are
  // registered yet line up with the state they belong to.
  always_comb begin
    sclk_d      = (state_n == S_HI);
    iclk_d      = (state_n == S_IRST) && ihi_n;
    sin_d       = (state_n == S_LO) ? tx_n[bit_n] : serial_in;
    rsp_valid_d = (state == S_SMP) && (bit_idx == 3'd0);
    rsp_data_d  = rsp_valid_d ? rx_n : rsp_data_q;
  end

  assign bus.cmd_ready = (state == S_IDLE) && rstn;
  assign bus.busy      = (state != S_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_psec5_spi_master.sv
module tb_psec5_spi_master;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- directed instance: CLK_DIV=2, IRST_PULSES=8 ----------------
  logic       a_rstn;
  logic       a_sclk, a_iclk, a_sin;
  logic       a_sout = 1'b0;
  logic [2:0] a_dbg;
`ifdef PSEC5_SPI_LOOPBACK_EN
  logic       a_loopback = 1'b0;
`endif
  psec5_spi_master_if a_bus();

  psec5_spi_master #(.CLK_DIV(2), .IRST_PULSES(8)) u_dut (
    .clk        (clk),
    .rstn       (a_rstn),
`ifdef PSEC5_SPI_LOOPBACK_EN
    .loopback   (a_loopback),
`endif
    .bus        (a_bus),
    .sclk       (a_sclk),
    .iclk       (a_iclk),
    .serial_in  (a_sin),
    .serial_out (a_sout),
    .dbg_state  (a_dbg)
  );

  // Slave model: records serial_in at each sclk rise, drives a_out_byte MSB-first.
  logic [7:0] a_out_byte = 8'h00;
  logic [7:0] a_rx_shift = 8'h00;
  logic [7:0] a_got_q[$];
  int         a_rises = 0;
  int         a_base  = 0;
  int         a_iclk_rises = 0;
  int         a_rsp_cnt = 0;
  int         a_rsp_cyc = 0;
  int         a_acc_cyc = 0;
  int         a_viol = 0;
  logic [7:0] a_rsp_data = 8'h00;
  logic       a_prev_sclk = 1'b0;
  logic       a_prev_sin  = 1'b0;

  always @(posedge a_sclk) begin
    logic [2:0] bp;
    bp = 3'(7 - ((a_rises - a_base) % 8));
    a_sout = a_out_byte[bp];
    a_rx_shift = {a_rx_shift[6:0], a_sin};
    a_rises++;
    if (((a_rises - a_base) % 8) == 0) a_got_q.push_back(a_rx_shift);
  end

  always @(posedge a_iclk) a_iclk_rises++;

  always @(negedge clk) begin
    if (a_sclk && a_iclk) a_viol++;
    if (a_sclk && a_prev_sclk && (a_sin !== a_prev_sin)) a_viol++;
    if (a_bus.rsp_valid) begin
      a_rsp_cnt++;
      a_rsp_cyc  = cyc;
      a_rsp_data = a_bus.rsp_data;
    end
    a_prev_sclk = a_sclk;
    a_prev_sin  = a_sin;
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic a_send(input logic [7:0] d, input logic l);
    int t = 0;
    while (a_bus.cmd_ready !== 1'b1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check_eq("a_ready", 32'(a_bus.cmd_ready), 1);
    a_bus.cmd_valid = 1'b1;
    a_bus.cmd_data  = d;
    a_bus.cmd_last  = l;
    a_acc_cyc       = cyc + 1;
    @(negedge clk);
    a_bus.cmd_valid = 1'b0;
  endtask

  task automatic a_wait_rsp(input int n0);
    int t = 0;
    while (a_rsp_cnt == n0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check_eq("a_rsp_seen", a_rsp_cnt, n0 + 1);
  endtask

  task automatic a_wait_idle();
    int t = 0;
    while (a_bus.busy !== 1'b0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check_eq("a_idle", 32'(a_bus.busy), 0);
  endtask

  // ---------------- random protocol runs: CLK_DIV 1 and 3 ----------------
  for (genvar g = 0; g < 2; g++) begin : g_rand
    localparam int D = (g == 0) ? 1 : 3;
    localparam int P = (g == 0) ? 3 : 2;
    localparam int N = 100;

    logic       rstn = 1'b0;
    logic       sclk, iclk, sin;
    logic       sout = 1'b0;
    logic [2:0] dbg;
    logic       done = 1'b0;
`ifdef PSEC5_SPI_LOOPBACK_EN
    logic       lb = 1'b0;
`endif
    psec5_spi_master_if bus();

    psec5_spi_master #(.CLK_DIV(D), .IRST_PULSES(P)) u_dut (
      .clk        (clk),
      .rstn       (rstn),
`ifdef PSEC5_SPI_LOOPBACK_EN
      .loopback   (lb),
`endif
      .bus        (bus),
      .sclk       (sclk),
      .iclk       (iclk),
      .serial_in  (sin),
      .serial_out (sout),
      .dbg_state  (dbg)
    );

    logic [7:0] exp_tx_q[$];   // bytes accepted, expected on serial_in
    logic [7:0] exp_rsp_q[$];  // bytes the slave drove, expected on rsp_data
    logic [7:0] out_byte = 8'h00;
    logic [7:0] rx_shift = 8'h00;
    int rises = 0, iclk_rises = 0, rsp_cnt = 0, tx_idx = 0, viol = 0;
    logic prev_sclk = 1'b0, prev_sin = 1'b0;

    always @(posedge sclk) begin
      logic [2:0] bp;
      if ((rises % 8) == 0) begin
        out_byte = 8'($urandom_range(0, 255));
        exp_rsp_q.push_back(out_byte);
      end
      bp = 3'(7 - (rises % 8));
      sout = out_byte[bp];
      rx_shift = {rx_shift[6:0], sin};
      rises++;
      if ((rises % 8) == 0) begin
        check_eq("rand_tx_avail", 32'(exp_tx_q.size() > tx_idx), 1);
        if (exp_tx_q.size() > tx_idx) check_eq("rand_tx", 32'(rx_shift), 32'(exp_tx_q[tx_idx]));
        tx_idx++;
      end
    end

    always @(posedge iclk) iclk_rises++;

    always @(negedge clk) begin
      if (sclk && iclk) viol++;
      if (sclk && prev_sclk && (sin !== prev_sin)) viol++;
      if (bus.rsp_valid) begin
        if (rsp_cnt < exp_rsp_q.size()) check_eq("rand_rsp", 32'(bus.rsp_data), 32'(exp_rsp_q[rsp_cnt]));
        else check_eq("rand_rsp_extra", rsp_cnt, exp_rsp_q.size());
        rsp_cnt++;
      end
      prev_sclk = sclk;
      prev_sin  = sin;
    end

    initial begin
      int n_last = 0;
      int n_irst = 0;
      int t;
      logic [7:0] d;
      logic l;
      bus.cmd_valid = 1'b0;
      bus.cmd_data  = 8'h00;
      bus.cmd_last  = 1'b0;
      bus.irst_req  = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        t = 0;
        while (!bus.cmd_ready && t < 1000) begin @(negedge clk); t++; end
        if (t >= 1000) check_eq("rand_ready", 32'(bus.cmd_ready), 1);
        if ($urandom_range(0, 7) == 0) begin
          bus.irst_req = 1'b1;
          n_irst++;
          @(negedge clk);
          bus.irst_req = 1'b0;
          t = 0;
          while (!bus.cmd_ready && t < 1000) begin @(negedge clk); t++; end
          if (t >= 1000) check_eq("rand_ready_irst", 32'(bus.cmd_ready), 1);
        end
        d = 8'($urandom_range(0, 255));
        l = ($urandom_range(0, 3) == 0);
        exp_tx_q.push_back(d);
        n_last += int'(l);
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = d;
        bus.cmd_last  = l;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
      end
      t = 0;
      while (bus.busy && t < 2000) begin @(negedge clk); t++; end
      repeat (2) @(negedge clk);
      check_eq("rand_busy_end", 32'(bus.busy), 0);
      check_eq("rand_rsp_count", rsp_cnt, N);
      check_eq("rand_sclk_rises", rises, 8 * N);
      check_eq("rand_iclk_rises", iclk_rises, P * (n_last + n_irst));
      check_eq("rand_invariants", viol, 0);
      done = 1'b1;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int r0, i0, n0, b0, t0, n, t;
    a_rstn = 1'b0;
    a_bus.cmd_valid = 1'b0;
    a_bus.cmd_data  = 8'h00;
    a_bus.cmd_last  = 1'b0;
    a_bus.irst_req  = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check_eq("rst_sclk", 32'(a_sclk), 0);
    check_eq("rst_iclk", 32'(a_iclk), 0);
    check_eq("rst_serial_in", 32'(a_sin), 0);
    check_eq("rst_rsp_valid", 32'(a_bus.rsp_valid), 0);
    check_eq("rst_rsp_data", 32'(a_bus.rsp_data), 0);
    check_eq("rst_busy", 32'(a_bus.busy), 0);
    check_eq("rst_cmd_ready", 32'(a_bus.cmd_ready), 0);
    a_rstn = 1'b1;
    @(negedge clk);
    check_eq("idle_cmd_ready", 32'(a_bus.cmd_ready), 1);

    // Basic write: 0x01 then 0x29 with reset burst
    a_base = a_rises;
    r0 = a_rises; i0 = a_iclk_rises; n0 = a_rsp_cnt; b0 = a_got_q.size();
    a_send(8'h01, 1'b0);
    a_send(8'h29, 1'b1);
    a_wait_idle();
    check_eq("wr_sclk_rises", a_rises - r0, 16);
    check_eq("wr_iclk_rises", a_iclk_rises - i0, 8);
    check_eq("wr_bytes", a_got_q.size() - b0, 2);
    check_eq("wr_byte0", 32'(a_got_q[b0]), 32'h01);
    check_eq("wr_byte1", 32'(a_got_q[b0 + 1]), 32'h29);
    check_eq("wr_rsp_count", a_rsp_cnt - n0, 2);

    // Readback 0xA5 and byte latency
    a_out_byte = 8'hA5;
    a_base = a_rises;
    n0 = a_rsp_cnt;
    a_send(8'h00, 1'b0);
    a_wait_rsp(n0);
    a_wait_idle();
    check_eq("rd_data", 32'(a_rsp_data), 32'hA5);
    check_eq("rd_latency", a_rsp_cyc - a_acc_cyc, 40);
    check_eq("rd_one_pulse", a_rsp_cnt - n0, 1);

    // Arbitration: irst_req and cmd_valid together
    r0 = a_rises; i0 = a_iclk_rises; n0 = a_rsp_cnt;
    a_base = a_rises;
    a_bus.irst_req  = 1'b1;
    a_bus.cmd_valid = 1'b1;
    a_bus.cmd_data  = 8'h5A;
    a_bus.cmd_last  = 1'b0;
    t0 = cyc + 1;
    @(negedge clk);
    a_bus.irst_req = 1'b0;
    n = 0;
    while (!a_bus.cmd_ready && n < 100) begin n++; @(negedge clk); end
    check_eq("arb_ready_low", n, 32);
    check_eq("arb_iclk_rises", a_iclk_rises - i0, 8);
    check_eq("arb_sclk_rises", a_rises - r0, 0);
    @(negedge clk);
    a_bus.cmd_valid = 1'b0;
    a_wait_rsp(n0);
    check_eq("arb_rsp_time", a_rsp_cyc - t0, 73);
    check_eq("arb_byte", 32'(a_got_q[a_got_q.size() - 1]), 32'h5A);
    a_wait_idle();

    // Abort during HI of bit 4
    r0 = a_rises; n0 = a_rsp_cnt;
    a_base = a_rises;
    a_send(8'hC3, 1'b0);
    t = 0;
    while ((a_rises - r0) < 4 && t < 500) begin @(negedge clk); t++; end
    check_eq("abort_in_hi", 32'(a_sclk), 1);
    a_rstn = 1'b0;
    #1;
    check_eq("abort_sclk", 32'(a_sclk), 0);
    check_eq("abort_iclk", 32'(a_iclk), 0);
    check_eq("abort_busy", 32'(a_bus.busy), 0);
    check_eq("abort_rsp_valid", 32'(a_bus.rsp_valid), 0);
    repeat (3) @(negedge clk);
    a_rstn = 1'b1;
    @(negedge clk);
    check_eq("abort_no_rsp", a_rsp_cnt, n0);
    a_base = a_rises;
    r0 = a_rises; b0 = a_got_q.size();
    a_send(8'hFF, 1'b0);
    a_wait_rsp(n0);
    a_wait_idle();
    check_eq("post_abort_rises", a_rises - r0, 8);
    check_eq("post_abort_bytes", a_got_q.size() - b0, 1);
    check_eq("post_abort_byte", 32'(a_got_q[b0]), 32'hFF);

`ifdef PSEC5_SPI_LOOPBACK_EN
    // Loopback: serial_out held at 1, rsp must echo the command byte
    a_loopback = 1'b1;
    a_out_byte = 8'hFF;
    a_base = a_rises;
    n0 = a_rsp_cnt;
    a_send(8'h3C, 1'b0);
    a_wait_rsp(n0);
    a_wait_idle();
    check_eq("loopback_data", 32'(a_rsp_data), 32'h3C);
    a_loopback = 1'b0;
`endif

    check_eq("dir_invariants", a_viol, 0);

    t = 0;
    while (!(g_rand[0].done && g_rand[1].done) && t < 50000) begin @(negedge clk); t++; end
    check_eq("rand_runs_done", 32'(g_rand[0].done && g_rand[1].done), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
